// File: rtl/mem_port_arbiter_pkg.sv
// riscv_defines: shared core/memory definitions.
//   RISCV_ADDR_WIDTH / RISCV_WORD_WIDTH : default bus widths
//   RISCV_BE_WIDTH                      : byte-enable width of a word access
//   arb_state_e                         : memory port arbiter FSM states
//   arb_last_e                          : which requester completed most recently
//   tie_winner()                        : round-robin pick when both requesters ask
package riscv_defines;

  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_BE_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } arb_last_e;

  // On a tie the requester that was NOT served last wins.
  function automatic arb_state_e tie_winner(input arb_last_e last);
    return (last == LAST_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// (imem) and data (dmem) ports of the core, round-robin on ties.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_* / dmem_*                 requester side: valid/addr/wdata/we in,
//                                   ready/rdata out (ready is a 1-cycle pulse)
//   mem_valid_o, mem_addr_o,
//   mem_wdata_o, mem_we_o           memory request, driven only while granted
//   mem_ready_i, mem_rdata_i        memory completion and read data
// Responses are passed through combinationally: a requester sees ready in the
// same cycle the memory does. Read data is broadcast to both requesters;
// each must only consume it together with its own ready.
module mem_port_arbiter
  import riscv_defines::*;
#(
  parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter int WORD_WIDTH = RISCV_WORD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      imem_valid_i,
  output logic                      imem_ready_o,
  input  logic [ADDR_WIDTH-1:0]     imem_addr_i,
  input  logic [WORD_WIDTH-1:0]     imem_wdata_i,
  input  logic [RISCV_BE_WIDTH-1:0] imem_we_i,
  output logic [WORD_WIDTH-1:0]     imem_rdata_o,

  input  logic                      dmem_valid_i,
  output logic                      dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0]     dmem_addr_i,
  input  logic [WORD_WIDTH-1:0]     dmem_wdata_i,
  input  logic [RISCV_BE_WIDTH-1:0] dmem_we_i,
  output logic [WORD_WIDTH-1:0]     dmem_rdata_o,

  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [WORD_WIDTH-1:0]     mem_wdata_o,
  output logic [RISCV_BE_WIDTH-1:0] mem_we_o,
  input  logic [WORD_WIDTH-1:0]     mem_rdata_i
);

  arb_state_e state, state_next;
  arb_last_e  last_gnt, last_gnt_next;

  // Reset acts immediately: all outputs below decode from state, so they
  // drop in the same cycle rst_n falls and any in-flight access is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= LAST_I;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    last_gnt_next = last_gnt;
    mem_valid_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_we_o      = '0;
    imem_ready_o  = 1'b0;
    dmem_ready_o  = 1'b0;

    case (state)
      IDLE: begin
        if (imem_valid_i && dmem_valid_i) begin
          state_next = tie_winner(last_gnt);
        end else if (imem_valid_i) begin
          state_next = GNT_I;
        end else if (dmem_valid_i) begin
          state_next = GNT_D;
        end
      end

      GNT_I: begin
        mem_valid_o  = 1'b1;
        mem_addr_o   = imem_addr_i;
        mem_wdata_o  = imem_wdata_i;
        mem_we_o     = imem_we_i;
        imem_ready_o = mem_ready_i;
        if (mem_ready_i) begin
          last_gnt_next = LAST_I;
          // Hand straight over to a waiting dmem so it never waits more
          // than one transaction and the port sees no idle bubble.
          if (dmem_valid_i) begin
            state_next = GNT_D;
          end else if (imem_valid_i) begin
            state_next = GNT_I;
          end else begin
            state_next = IDLE;
          end
        end
      end

      GNT_D: begin
        mem_valid_o  = 1'b1;
        mem_addr_o   = dmem_addr_i;
        mem_wdata_o  = dmem_wdata_i;
        mem_we_o     = dmem_we_i;
        dmem_ready_o = mem_ready_i;
        if (mem_ready_i) begin
          last_gnt_next = LAST_D;
          if (imem_valid_i) begin
            state_next = GNT_I;
          end else if (dmem_valid_i) begin
            state_next = GNT_D;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

  // A granted requester must keep valid up until the cycle its ready is
  // seen; it may withdraw in that completion cycle.
  imem_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (state == GNT_I && !mem_ready_i) |-> imem_valid_i);

  dmem_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (state == GNT_D && !mem_ready_i) |-> dmem_valid_i);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default RISCV_ADDR_WIDTH (32), byte address width.
REQ-002 SHALL have parameter WORD_WIDTH, default RISCV_WORD_WIDTH (32), data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports imem_valid_i / dmem_valid_i  input  1  requester request held until its ready.
REQ-006 SHALL have ports imem_ready_o / dmem_ready_o  output  1  one-cycle completion pulse per requester.
REQ-007 SHALL have ports imem_addr_i / dmem_addr_i  input  ADDR_WIDTH  requester address.
REQ-008 SHALL have ports imem_wdata_i / dmem_wdata_i  input  WORD_WIDTH  requester write data.
REQ-009 SHALL have ports imem_we_i / dmem_we_i  input  4  byte write enables; 0 means read.
REQ-010 SHALL have ports imem_rdata_o / dmem_rdata_o  output  WORD_WIDTH  read data, valid only with own ready.
REQ-011 SHALL have ports mem_valid_o  output  1, mem_ready_i  input  1  single-port memory handshake.
REQ-012 SHALL have ports mem_addr_o  output  ADDR_WIDTH, mem_wdata_o  output  WORD_WIDTH, mem_we_o  output  4, mem_rdata_i  input  WORD_WIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, GNT_I, GNT_D; reset state IDLE.
REQ-014 IDLE: only one valid -> grant that requester next cycle; neither -> stay IDLE.
REQ-015 IDLE, both valid: grant requester indicated by last_gnt flag's opposite (round robin); last_gnt resets to I, so first tie goes to D.
REQ-016 In GNT_x: mem_valid_o=1; mem_addr_o/wdata_o/we_o combinationally muxed from granted requester.
REQ-017 In IDLE: mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0.
REQ-018 x_ready_o SHALL equal mem_ready_i AND state==GNT_x, same cycle (zero added response latency).
REQ-019 imem_rdata_o and dmem_rdata_o SHALL both be driven from mem_rdata_i (broadcast).
REQ-020 On mem_ready_i in GNT_x: set last_gnt=x; if other requester valid -> GNT_other next cycle (no idle bubble); else if x valid again -> GNT_x; else IDLE.
REQ-021 Request latency: valid sampled in IDLE at edge N -> mem_valid_o high from cycle N+1.
REQ-022 Starvation bound: a held request SHALL be granted after at most one other completed transaction.
REQ-023 Without mem_ready_i the grant SHALL hold indefinitely; no timeout.
REQ-024 Requester dropping valid before ready is a protocol violation; assertion SHALL flag it (simulation only).
REQ-025 Non-granted ready_o SHALL be 0 in every cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, last_gnt=I, all ready_o=0, mem_valid_o=0, regardless of in-flight transaction.
REQ-027 A transaction cut by reset SHALL be dropped; requester must reissue after reset.

Structure
REQ-028 FSM enum arb_state_e {IDLE, GNT_I, GNT_D} SHALL live in shared package riscv_defines next to RISCV_ADDR_WIDTH/RISCV_WORD_WIDTH.
REQ-029 No sub-module; single flat module, instantiated between riscv_core and a single-port RAM.

Verification
REQ-030 Only imem_valid=1, addr=0x100, memory ready after 2 cycles, rdata=0xDEADBEEF -> mem_valid high cycle 1, imem_ready pulse cycle 3 with imem_rdata=0xDEADBEEF, dmem_ready stays 0.
REQ-031 Both valid after reset, dmem write addr=0x000FFFFF we=0xF wdata=0x41000000, mem_ready immediate -> D served first, mem_we=0xF; I granted next cycle with no IDLE bubble.
REQ-032 Both held valid, 6 back-to-back single-cycle transactions -> grants alternate D,I,D,I,D,I.
REQ-033 rst_n low while GNT_D, mem_ready=0 -> same cycle mem_valid_o=0, all ready_o=0; after release, state IDLE, next tie grants D.
REQ-034 mem_ready held 0 for 50 cycles in GNT_I with dmem valid -> mem_addr stays imem_addr, dmem_ready 0 throughout, no state change.
REQ-035 imem_valid dropped mid-GNT_I -> protocol assertion fires.
